prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_if.sv | 26 ++
 rtl/prog_loader.sv | 168 ++++++++++++++++
 tb/tb_prog_loader.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Bus bundle between prog_loader and its environment.
//   uart_empty / uart_in / uart_rdreq : show-ahead receive FIFO (head byte + pop)
//   mem_we / mem_addr / mem_wdata     : single-cycle word write port
//   cpu_run / load_err / words_loaded : load status towards the CPU
// master = prog_loader side, slave = FIFO / memory / CPU side.
interface prog_loader_if;
  logic        uart_empty;
  logic [7:0]  uart_in;
  logic        uart_rdreq;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_run;
  logic        load_err;
  logic [31:0] words_loaded;

  modport master (
    input  uart_empty, uart_in,
    output uart_rdreq, mem_we, mem_addr, mem_wdata, cpu_run, load_err, words_loaded
  );

  modport slave (
    output uart_empty, uart_in,
    input  uart_rdreq, mem_we, mem_addr, mem_wdata, cpu_run, load_err, words_loaded
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: pulls a length-prefixed, XOR-checksummed program from a UART
// receive FIFO, writes it word by word into memory starting at BASE_ADDR and
// then releases the CPU (or flags an error and keeps the CPU stalled).
// Stream format: 4-byte LE length N (words), N x 4-byte LE words, 1 checksum
// byte equal to the XOR of all data bytes.
// Ports:
//   clk    : single clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : prog_loader_if.master (UART FIFO in, memory write out, status out)
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_LEN   | collecting the 4 length bytes
// S_DATA  | collecting program words, one write pulse per completed word
// S_CSUM  | waiting for the checksum byte
// S_DONE  | load good, CPU released, no further bytes consumed
// S_ERROR | bad length or checksum, CPU held, exit only by reset
module prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 4096
) (
  input  logic          clk,
  input  logic          rst_n,
  prog_loader_if.master bus
);

  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_LEN   = 3'd0,
    S_DATA  = 3'd1,
    S_CSUM  = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] asm_q, asm_d;          // lower three bytes of the word/length in flight
  logic [31:0] len_q, len_d;
  logic [31:0] wcnt_q, wcnt_d;        // words fully received
  logic [7:0]  xor_q, xor_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        cpu_run_q, cpu_run_d;
  logic        load_err_q, load_err_d;
  logic [31:0] words_loaded_q, words_loaded_d;

  logic        rd_en;
  logic        last_byte;
  logic [31:0] full_word;

  // The 4th byte completes the word straight from the FIFO head.
  assign full_word = {bus.uart_in, asm_q};
  assign last_byte = rd_en && (byte_cnt_q == 2'd3);

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_LEN;
    else        state_q <= state_d;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LEN: begin
        if (last_byte) begin
          if (full_word == 32'd0)      state_d = S_CSUM;
          else if (full_word > MAX_W)  state_d = S_ERROR;
          else                         state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (last_byte && (wcnt_q + 32'd1 == len_q)) state_d = S_CSUM;
      end
      S_CSUM: begin
        if (rd_en) state_d = (bus.uart_in == xor_q) ? S_DONE : S_ERROR;
      end
      default: state_d = state_q;
    endcase
  end

  // ---------------- FSM outputs ----------------
  // Gated by rst_n so the FIFO is never popped while reset is held.
  always_comb begin
    rd_en = 1'b0;
    if (rst_n && !bus.uart_empty &&
        (state_q == S_LEN || state_q == S_DATA || state_q == S_CSUM))
      rd_en = 1'b1;
  end

  // ---------------- datapath next values ----------------
  always_comb begin
    byte_cnt_d     = byte_cnt_q;
    asm_d          = asm_q;
    len_d          = len_q;
    wcnt_d         = wcnt_q;
    xor_d          = xor_q;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    words_loaded_d = words_loaded_q + {31'd0, mem_we_q};
    cpu_run_d      = (state_d == S_DONE);
    load_err_d     = (state_d == S_ERROR);

    if (rd_en && (state_q == S_LEN || state_q == S_DATA)) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      case (byte_cnt_q)
        2'd0:    asm_d[7:0]   = bus.uart_in;
        2'd1:    asm_d[15:8]  = bus.uart_in;
        2'd2:    asm_d[23:16] = bus.uart_in;
        default: asm_d        = asm_q;
      endcase
    end

    if (last_byte && state_q == S_LEN) len_d = full_word;

    if (rd_en && state_q == S_DATA) begin
      xor_d = xor_q ^ bus.uart_in;
      if (byte_cnt_q == 2'd3) begin
        mem_we_d    = 1'b1;
        mem_wdata_d = full_word;
        mem_addr_d  = BASE_ADDR + (wcnt_q << 2);
        wcnt_d      = wcnt_q + 32'd1;
      end
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q     <= 2'd0;
      asm_q          <= 24'd0;
      len_q          <= 32'd0;
      wcnt_q         <= 32'd0;
      xor_q          <= 8'd0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= BASE_ADDR;
      mem_wdata_q    <= 32'd0;
      cpu_run_q      <= 1'b0;
      load_err_q     <= 1'b0;
      words_loaded_q <= 32'd0;
    end else begin
      byte_cnt_q     <= byte_cnt_d;
      asm_q          <= asm_d;
      len_q          <= len_d;
      wcnt_q         <= wcnt_d;
      xor_q          <= xor_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      cpu_run_q      <= cpu_run_d;
      load_err_q     <= load_err_d;
      words_loaded_q <= words_loaded_d;
    end
  end

  assign bus.uart_rdreq   = rd_en;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.cpu_run      = cpu_run_q;
  assign bus.load_err     = load_err_q;
  assign bus.words_loaded = words_loaded_q;

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: byte-stream reference model driven by the
// position of each consumed byte in the stream, checked every cycle, plus
// literal expectations for the directed loads.
module tb_prog_loader;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 4096;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  prog_loader_if bus();

  prog_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  fifo[$];
  logic [31:0] wlog_addr[$];
  logic [31:0] wlog_data[$];
  int          stall_mode;
  int          cyc;

  // reference model state (values visible after the most recent edge)
  longint      m_pos;
  logic [31:0] m_len, m_acc, m_addr, m_data, m_words;
  logic [7:0]  m_xor;
  bit          m_fin, m_run, m_err, m_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_len = 0; m_acc = 0; m_xor = 0;
    m_fin = 0; m_run = 0; m_err = 0; m_we = 0;
    m_addr = BASE; m_data = 0; m_words = 0;
  endtask

  // Classify a consumed byte by its position in the stream.
  task automatic model_byte(input logic [7:0] b);
    longint d;
    int p;
    if (m_pos < 4) begin
      p = int'(m_pos);
      m_len = m_len | (32'(b) << (8 * p));
      if (p == 3 && m_len > 32'(MAXW)) begin
        m_err = 1; m_fin = 1;
      end
    end else if (m_pos < 4 + 4 * longint'(m_len)) begin
      d = m_pos - 4;
      m_acc = m_acc | (32'(b) << (8 * int'(d % 4)));
      m_xor = m_xor ^ b;
      if (d % 4 == 3) begin
        m_we   = 1;
        m_addr = BASE + 32'(4 * (d / 4));
        m_data = m_acc;
        m_acc  = 0;
      end
    end else begin
      if (b == m_xor) m_run = 1;
      else            m_err = 1;
      m_fin = 1;
    end
    m_pos++;
  endtask

  // One clock: drive FIFO head, compare all outputs, advance model on a pop.
  task automatic step();
    bit stall;
    logic [7:0] b;
    @(negedge clk);
    case (stall_mode)
      1:       stall = (cyc % 2 == 1);
      2:       stall = ($urandom_range(0, 2) == 0);
      default: stall = 0;
    endcase
    bus.uart_empty = (fifo.size() == 0) || stall;
    bus.uart_in    = (fifo.size() != 0) ? fifo[0] : 8'($urandom);
    #1;
    chk("uart_rdreq",   32'(bus.uart_rdreq), 32'(!bus.uart_empty && !m_fin));
    chk("mem_we",       32'(bus.mem_we),     32'(m_we));
    chk("mem_addr",     bus.mem_addr,        m_addr);
    chk("mem_wdata",    bus.mem_wdata,       m_data);
    chk("words_loaded", bus.words_loaded,    m_words);
    chk("cpu_run",      32'(bus.cpu_run),    32'(m_run));
    chk("load_err",     32'(bus.load_err),   32'(m_err));
    if (bus.mem_we) begin
      wlog_addr.push_back(bus.mem_addr);
      wlog_data.push_back(bus.mem_wdata);
    end
    m_words = m_words + 32'(m_we);
    m_we = 0;
    if (bus.uart_rdreq && fifo.size() != 0) begin
      b = fifo.pop_front();
      model_byte(b);
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.uart_empty = 1'b0;
    bus.uart_in    = 8'h5A;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rdreq",   32'(bus.uart_rdreq), 32'd0);
    chk("rst_mem_we",  32'(bus.mem_we),     32'd0);
    chk("rst_addr",    bus.mem_addr,        BASE);
    chk("rst_wdata",   bus.mem_wdata,       32'd0);
    chk("rst_run",     32'(bus.cpu_run),    32'd0);
    chk("rst_err",     32'(bus.load_err),   32'd0);
    chk("rst_words",   bus.words_loaded,    32'd0);
    model_reset();
    fifo.delete();
    wlog_addr.delete();
    wlog_data.delete();
    @(negedge clk);
    bus.uart_empty = 1'b1;
    rst_n = 1'b1;
  endtask

  task automatic run_load(input logic [7:0] s[$], input int mode, input int extra,
                          input longint abort_pos, input int exp_remaining, input string tag);
    int budget;
    int n;
    fifo = s;
    for (int i = 0; i < extra; i++) fifo.push_back(8'($urandom));
    stall_mode = mode;
    cyc = 0;
    budget = 4 * fifo.size() + 40;
    n = 0;
    while (!m_fin && n < budget) begin
      if (abort_pos >= 0 && m_pos == abort_pos) begin
        do_reset();
        return;
      end
      step();
      n++;
    end
    chk({"finished_", tag}, 32'(m_fin), 32'd1);
    repeat (6) step();
    chk({"remaining_", tag}, 32'(fifo.size()), 32'(exp_remaining));
  endtask

  task automatic build_random(input int nw, input bit bad, output logic [7:0] s[$]);
    logic [7:0] x;
    logic [31:0] l;
    s.delete();
    x = 0;
    l = 32'(nw);
    for (int i = 0; i < 4; i++) s.push_back(l[8*i +: 8]);
    for (int i = 0; i < 4 * nw; i++) begin
      s.push_back(8'($urandom));
      x = x ^ s[s.size() - 1];
    end
    s.push_back(bad ? (x ^ 8'(1 + $urandom_range(0, 254))) : x);
  endtask

  logic [7:0] st[$];

  initial begin
    rst_n = 1'b0;
    bus.uart_empty = 1'b1;
    bus.uart_in = 8'h00;
    stall_mode = 0;
    model_reset();
    do_reset();

    // Two words back to back; the XOR of the eight data bytes is 0x88.
    st = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
           8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
    run_load(st, 0, 3, -1, 3, "two_words");
    chk("tw_nwrites", 32'(wlog_addr.size()), 32'd2);
    if (wlog_addr.size() == 2) begin
      chk("tw_addr0", wlog_addr[0], 32'h0000_0000);
      chk("tw_data0", wlog_data[0], 32'h4433_2211);
      chk("tw_addr1", wlog_addr[1], 32'h0000_0004);
      chk("tw_data1", wlog_data[1], 32'h8877_6655);
    end
    chk("tw_words", bus.words_loaded, 32'd2);
    chk("tw_run",   32'(bus.cpu_run),  32'd1);
    chk("tw_err",   32'(bus.load_err), 32'd0);

    // Same stream, wrong checksum.
    do_reset();
    st[12] = 8'h00;
    run_load(st, 0, 4, -1, 4, "bad_csum");
    chk("bc_nwrites", 32'(wlog_addr.size()), 32'd2);
    chk("bc_err", 32'(bus.load_err), 32'd1);
    chk("bc_run", 32'(bus.cpu_run),  32'd0);

    // Zero length, good and bad checksum.
    do_reset();
    st = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_load(st, 0, 2, -1, 2, "len0_ok");
    chk("z0_nwrites", 32'(wlog_addr.size()), 32'd0);
    chk("z0_run", 32'(bus.cpu_run), 32'd1);
    do_reset();
    st = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    run_load(st, 0, 2, -1, 2, "len0_bad");
    chk("z1_err", 32'(bus.load_err), 32'd1);

    // Length MAX_WORDS+1 (0x1001) rejected after the 4th length byte.
    do_reset();
    st = '{8'h01, 8'h10, 8'h00, 8'h00};
    run_load(st, 0, 5, -1, 5, "too_long");
    chk("tl_nwrites", 32'(wlog_addr.size()), 32'd0);
    chk("tl_err", 32'(bus.load_err), 32'd1);

    // Exactly MAX_WORDS is accepted.
    do_reset();
    build_random(MAXW, 0, st);
    run_load(st, 0, 2, -1, 2, "max_len");
    chk("mx_words", bus.words_loaded, 32'(MAXW));
    chk("mx_run", 32'(bus.cpu_run), 32'd1);
    chk("mx_last_addr", bus.mem_addr, BASE + 32'h0000_3FFC);

    // One word with the FIFO empty every other cycle; XOR DE^AD^BE^EF = 0x22.
    do_reset();
    st = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    run_load(st, 1, 2, -1, 2, "toggle");
    chk("tg_nwrites", 32'(wlog_addr.size()), 32'd1);
    if (wlog_addr.size() == 1) begin
      chk("tg_addr", wlog_addr[0], 32'h0000_0000);
      chk("tg_data", wlog_data[0], 32'hEFBE_ADDE);
    end
    chk("tg_run", 32'(bus.cpu_run), 32'd1);
    chk("tg_words", bus.words_loaded, 32'd1);

    // Reset after two bytes of the first word, then a full good load.
    do_reset();
    st = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
           8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
    run_load(st, 0, 0, 6, 0, "abort");
    stall_mode = 0;
    repeat (5) step();
    chk("ab_nwrites_idle", 32'(wlog_addr.size()), 32'd0);
    run_load(st, 0, 0, -1, 0, "after_abort");
    chk("ab_nwrites", 32'(wlog_addr.size()), 32'd2);
    if (wlog_addr.size() == 2) begin
      chk("ab_addr0", wlog_addr[0], BASE);
      chk("ab_data0", wlog_data[0], 32'h4433_2211);
    end
    chk("ab_run", 32'(bus.cpu_run), 32'd1);

    // Randomized loads with random FIFO gaps and occasional bad checksums.
    for (int it = 0; it < 12; it++) begin
      bit bad;
      int nw;
      do_reset();
      nw  = $urandom_range(1, 8);
      bad = ($urandom_range(0, 3) == 0);
      build_random(nw, bad, st);
      run_load(st, 2 * $urandom_range(0, 1), 3, -1, 3, "random");
      chk("rnd_nwrites", 32'(wlog_addr.size()), 32'(nw));
      chk("rnd_err", 32'(bus.load_err), 32'(bad));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
